bus_read_sequencer: RTL and testbench

- Read-side controller for the shared tri-state register bus in the CPU datapath.
- Register flip-flop blocks drive the bus only while their active-low `cs` is 0, and release it to Z while `cs` is 1.
- This block accepts a read request for one source register, drops that register's `cs` for a settle window, captures the resolved bus value and returns it over a valid/ready response channel.
- It guarantees that at most one source drives the bus at any time.

---
 rtl/bus_read_sequencer.sv | 137 +++++++++++++
 tb/tb_bus_read_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_read_sequencer.sv
// Read sequencer for the shared tri-state register bus: selects one source via cs, captures the bus, returns it.
// Optional macro BUS_READ_SEQUENCER_BACK_TO_BACK_EN lets a new request be accepted in the same tick a response completes.
module bus_read_sequencer #(
  parameter int unsigned NrOfBits     = 8,
  parameter int unsigned NrOfSources  = 4,
  parameter int unsigned SelBits      = 2,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   ClockEnable,
  input  logic                   Tick,
  input  logic                   ReqValid,
  input  logic [SelBits-1:0]     ReqSel,
  output logic                   ReqReady,
  input  logic [NrOfBits-1:0]    BusIn,
  output logic [NrOfSources-1:0] cs,
  output logic                   RspValid,
  output logic [NrOfBits-1:0]    RspData,
  output logic [SelBits-1:0]     RspSel,
  output logic                   RspErr,
  input  logic                   RspReady,
  output logic                   Busy
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NrOfSources-1:0] cs_q, cs_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0]    rsp_data_q, rsp_data_d;
  logic [SelBits-1:0]     rsp_sel_q, rsp_sel_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   enabled;
  logic                   sel_ok;
  logic                   accept;

  assign enabled = ClockEnable & Tick;
  assign sel_ok  = 32'(ReqSel) < NrOfSources;

`ifdef BUS_READ_SEQUENCER_BACK_TO_BACK_EN
  assign ReqReady = (state_q == IDLE) || ((state_q == RESP) && RspReady);
`else
  assign ReqReady = (state_q == IDLE);
`endif
  assign Busy     = (state_q != IDLE);
  assign cs       = cs_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspSel   = rsp_sel_q;
  assign RspErr   = rsp_err_q;

  // Next-state and next-output logic; everything holds unless there is an enabled tick
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_err_d   = rsp_err_q;
    accept      = 1'b0;
    cs_d        = '1;

    if (enabled) begin
      case (state_q)
        IDLE: begin
          accept = ReqValid;
        end
        DRIVE: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(SettleCycles - 1)) begin
            rsp_data_d  = BusIn;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
        RESP: begin
          if (RspReady) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
`ifdef BUS_READ_SEQUENCER_BACK_TO_BACK_EN
            accept      = ReqValid;
`endif
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        rsp_sel_d = ReqSel;
        if (sel_ok) begin
          cnt_d   = '0;
          state_d = DRIVE;
        end else begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
    end

    // cs is registered from the next state so it changes only on clock edges
    for (int i = 0; i < int'(NrOfSources); i++) begin
      cs_d[i] = !((state_d == DRIVE) && (rsp_sel_d == SelBits'(i)));
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cs_q        <= '1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Scoreboard bench for bus_read_sequencer: 3 sources, 3-tick settle window, randomized tick/enable/backpressure.
module tb_bus_read_sequencer;

  localparam int unsigned NB     = 8;
  localparam int unsigned NS     = 3;
  localparam int unsigned SB     = 2;
  localparam int unsigned SETTLE = 3;
  localparam int          MAXWAIT = 2000;

  typedef struct {
    logic [NB-1:0] data;
    logic [SB-1:0] sel;
    logic          err;
  } rsp_t;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          ClockEnable = 1'b1;
  logic          Tick = 1'b1;
  logic          ReqValid = 1'b0;
  logic [SB-1:0] ReqSel = '0;
  logic          ReqReady;
  logic [NB-1:0] BusIn;
  logic [NS-1:0] cs;
  logic          RspValid;
  logic [NB-1:0] RspData;
  logic [SB-1:0] RspSel;
  logic          RspErr;
  logic          RspReady = 1'b1;
  logic          Busy;

  int vectors = 0;
  int errors  = 0;

  logic [NB-1:0] regs [NS];
  rsp_t sb[$];

  // Reference model: ticks left with a source selected, which source, and whether a response is owed
  int   m_drv_left = 0;
  int   m_drv_sel  = 0;
  logic m_rsp      = 1'b0;
  logic armed      = 1'b0;

  int tick_mode = 0;
  int rdy_mode  = 1;
  int ce_rand   = 0;
  int tcnt      = 0;

  bus_read_sequencer #(
    .NrOfBits(NB), .NrOfSources(NS), .SelBits(SB), .SettleCycles(SETTLE)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .ReqValid(ReqValid), .ReqSel(ReqSel), .ReqReady(ReqReady), .BusIn(BusIn),
    .cs(cs), .RspValid(RspValid), .RspData(RspData), .RspSel(RspSel),
    .RspErr(RspErr), .RspReady(RspReady), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Shared bus: the single selected register drives it, otherwise it floats to a recognisable junk value
  always_comb begin
    BusIn = 8'hEE;
    for (int i = 0; i < int'(NS); i++)
      if (cs == ~(NS'(1) << i)) BusIn = regs[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment: tick pattern, enable and consumer readiness
  always @(posedge Clock) begin
    #1;
    tcnt++;
    case (tick_mode)
      0:       Tick = 1'b1;
      1:       Tick = (tcnt % 4 == 0);
      default: Tick = 1'($urandom_range(0, 1));
    endcase
    ClockEnable = (ce_rand != 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
    case (rdy_mode)
      0:       RspReady = 1'b0;
      1:       RspReady = 1'b1;
      default: RspReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares DUT against the model, then advances the model for the coming edge
  always @(negedge Clock) begin
    logic [NS-1:0] exp_cs;
    logic          exp_rdy;
    logic          idle;
    if (armed) begin
      exp_cs = '1;
      if (m_drv_left > 0) exp_cs[m_drv_sel] = 1'b0;
      idle    = (m_drv_left == 0) && !m_rsp;
      exp_rdy = idle;
`ifdef BUS_READ_SEQUENCER_BACK_TO_BACK_EN
      if (m_rsp && RspReady) exp_rdy = 1'b1;
`endif
      chk("cs", 32'(cs), 32'(exp_cs));
      chk("cs_single_driver", 32'($countones(~cs) <= 1), 32'(1));
      chk("ReqReady", 32'(ReqReady), 32'(exp_rdy));
      chk("Busy", 32'(Busy), 32'(!idle));
      chk("RspValid", 32'(RspValid), 32'(m_rsp));
      if (m_rsp) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got response %0h expected none at %0t", RspData, $time);
        end else begin
          chk("RspData", 32'(RspData), 32'(sb[0].data));
          chk("RspSel", 32'(RspSel), 32'(sb[0].sel));
          chk("RspErr", 32'(RspErr), 32'(sb[0].err));
        end
      end
      if (Reset) begin
        m_drv_left = 0;
        m_rsp      = 1'b0;
        sb.delete();
      end else if (ClockEnable && Tick) begin
        if (m_rsp && RspReady) begin
          m_rsp = 1'b0;
          if (sb.size() > 0) void'(sb.pop_front());
        end
        if (m_drv_left > 0) begin
          m_drv_left--;
          if (m_drv_left == 0) m_rsp = 1'b1;
        end
        if (ReqValid && exp_rdy) begin
          if (int'(ReqSel) < int'(NS)) begin
            m_drv_left = SETTLE;
            m_drv_sel  = int'(ReqSel);
          end else begin
            m_rsp = 1'b1;
          end
        end
      end
    end
    if (Reset) armed = 1'b1;
  end

  // Issue one request, hold it until accepted, then push the expected response
  task automatic do_req(input logic [SB-1:0] sel);
    int   n = 0;
    rsp_t e;
    ReqValid = 1'b1;
    ReqSel   = sel;
    forever begin
      @(negedge Clock);
      if (ReqReady && ClockEnable && Tick && !Reset) break;
      n++;
      if (n > MAXWAIT) break;
    end
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    if (n > MAXWAIT) begin
      errors++;
      $display("FAIL req_accept_timeout: got no accept expected accept of sel %0d", sel);
    end else begin
      e.err  = (int'(sel) >= int'(NS));
      e.sel  = sel;
      e.data = e.err ? '0 : regs[sel];
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || m_drv_left != 0 || m_rsp) && n < MAXWAIT) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_timeout", 32'(n < MAXWAIT), 32'(1));
    @(posedge Clock);
    #1;
  endtask

  task automatic rand_regs();
    for (int i = 0; i < int'(NS); i++) regs[i] = NB'($urandom);
  endtask

  initial begin
    rand_regs();
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Basic reads, every tick enabled, including the invalid source
    regs[2] = 8'hA5;
    do_req(2'd2);
    wait_idle();
    do_req(2'd0);
    do_req(2'd1);
    do_req(2'd3);
    wait_idle();

    // Tick every 4th cycle: settle window stretches to 12 clocks
    tick_mode = 1;
    regs[0]   = 8'h3C;
    do_req(2'd0);
    do_req(2'd3);
    wait_idle();

    // Backpressure: consumer stalls while a second request waits
    tick_mode = 0;
    rdy_mode  = 0;
    rand_regs();
    do_req(2'd1);
    fork
      begin
        repeat (15) @(posedge Clock);
        #1;
        rdy_mode = 1;
      end
    join_none
    do_req(2'd2);
    wait_idle();

    // Reset while source 1 is being driven, then a normal read
    tick_mode = 1;
    do_req(2'd1);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    tick_mode = 0;
    do_req(2'd2);
    wait_idle();

    // Randomized traffic with random ticks, enables and backpressure
    tick_mode = 2;
    ce_rand   = 1;
    rdy_mode  = 2;
    rand_regs();
    for (int k = 0; k < 60; k++) begin
      do_req(SB'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      #1;
    end
    wait_idle();

    // Back-to-back reads with consumer always ready
    tick_mode = 0;
    ce_rand   = 0;
    rdy_mode  = 1;
    rand_regs();
    do_req(2'd1);
    do_req(2'd3);
    for (int k = 0; k < 10; k++) do_req(SB'($urandom_range(0, 3)));
    wait_idle();

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
